// File: rtl/gift_128_core_param_if.sv
// gift_128_core_param_if: host-side key/data handshake for the GIFT-128 core.
// key_clr exists only when GIFT128_KEY_CLEAR_EN is defined.
interface gift_128_core_param_if;
  logic [127:0] key_in;
  logic         key_ld;
  logic         key_ready;
  logic         mode;
  logic [127:0] data_in;
  logic         start;
  logic [127:0] data_out;
  logic         done;
  logic         busy;
`ifdef GIFT128_KEY_CLEAR_EN
  logic         key_clr;
`endif

  modport master (
    output key_in, key_ld, mode,
    output data_in, start,
`ifdef GIFT128_KEY_CLEAR_EN
    output key_clr,
`endif
    input  key_ready, data_out,
    input  done, busy
  );

  modport slave (
    input  key_in, key_ld, mode,
    input  data_in, start,
`ifdef GIFT128_KEY_CLEAR_EN
    input  key_clr,
`endif
    output key_ready, data_out,
    output done, busy
  );
endinterface

// File: rtl/gift_128_core_param.sv
// gift_128_core_param: GIFT-128 enc/dec core, UNROLL rounds per clock.
// Optional key wipe input enabled by GIFT128_KEY_CLEAR_EN.
module gift_128_core_param #(
  parameter int UNROLL = 1,
  parameter int ROUNDS = 40
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  gift_128_core_param_if.slave  bus
);
  localparam int USAFE = (UNROLL < 1) ? 1 : UNROLL;
  localparam int NCYC = ROUNDS / USAFE;
  localparam logic [5:0] LAST = 6'(NCYC - 1);
  localparam logic [5:0] RMAX = 6'(ROUNDS - 1);

  if (ROUNDS != 40) begin : g_bad_rounds
    $error("gift_128_core_param: ROUNDS must be 40");
  end
  if (UNROLL < 1 || UNROLL > 40 || (40 % USAFE) != 0)
  begin : g_bad_unroll
    $error("gift_128_core_param: UNROLL must divide 40");
  end

  localparam logic [3:0] SBOX [16] = '{
    4'h1, 4'hA, 4'h4, 4'hC, 4'h6, 4'hF, 4'h3, 4'h9,
    4'h2, 4'hD, 4'hB, 4'h7, 4'h5, 4'h0, 4'h8, 4'hE
  };
  localparam logic [3:0] ISBOX [16] = '{
    4'hD, 4'h0, 4'h8, 4'h6, 4'h2, 4'hC, 4'h4, 4'hB,
    4'hE, 4'h7, 4'h1, 4'hA, 4'h3, 4'h9, 4'hF, 4'h5
  };
  localparam logic [5:0] RC_T [40] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
    6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E,
    6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
    6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38,
    6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
  };

  function automatic logic [127:0] sub_cells(
    input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 32; i++)
      o[4*i +: 4] = inv ? ISBOX[s[4*i +: 4]] : SBOX[s[4*i +: 4]];
    return o;
  endfunction

  function automatic int pos(input int i);
    return 4*(i/16) + 32*((3*((i%16)/4) + i%4) % 4) + i%4;
  endfunction

  function automatic logic [127:0] perm(
    input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 128; i++) begin
      if (inv) o[i] = s[pos(i)];
      else     o[pos(i)] = s[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] add_rk(
    input logic [127:0] s, input logic [127:0] k,
    input logic [5:0] rc);
    logic [127:0] o;
    o = s;
    for (int i = 0; i < 32; i++) begin
      o[4*i+2] = o[4*i+2] ^ k[64+i];
      o[4*i+1] = o[4*i+1] ^ k[i];
    end
    o[127] = ~o[127];
    o[23] = o[23] ^ rc[5];
    o[19] = o[19] ^ rc[4];
    o[15] = o[15] ^ rc[3];
    o[11] = o[11] ^ rc[2];
    o[7]  = o[7]  ^ rc[1];
    o[3]  = o[3]  ^ rc[0];
    return o;
  endfunction

  function automatic logic [127:0] upd(input logic [127:0] k);
    return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
  endfunction

  function automatic logic [127:0] inv_upd(input logic [127:0] n);
    return {n[95:0], n[125:112], n[127:126], n[99:96], n[111:100]};
  endfunction

  typedef enum logic [1:0] {IDLE, KEY_PREP, RUN, DONE} state_e;

  state_e       st, st_nx;
  logic [5:0]   cnt;
  logic [127:0] sreg, kreg, k0_reg, k40_reg;
  logic         mode_r, kr;
  logic         clr, last;
  logic [127:0] s_run, k_run, k_prep;
  logic [5:0]   fwd;

`ifdef GIFT128_KEY_CLEAR_EN
  assign clr = bus.key_clr;
`else
  assign clr = 1'b0;
`endif

  assign last = (cnt == LAST);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (clr) begin
      st_nx = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.key_ld)           st_nx = KEY_PREP;
          else if (bus.start && kr) st_nx = RUN;
        end
        KEY_PREP: if (last) st_nx = IDLE;
        RUN:      if (last) st_nx = DONE;
        DONE:     st_nx = IDLE;
        default:  st_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = (st != IDLE);
    bus.done = (st == DONE);
  end

  assign bus.data_out  = sreg;
  assign bus.key_ready = kr;

  // Decryption walks the schedule backwards from K40, one inverse step per round.
  always_comb begin
    s_run  = sreg;
    k_run  = kreg;
    k_prep = kreg;
    fwd    = '0;
    for (int j = 0; j < USAFE; j++) begin
      fwd    = 6'(int'(cnt) * USAFE + j);
      k_prep = upd(k_prep);
      if (!mode_r) begin
        s_run = perm(sub_cells(s_run, 1'b0), 1'b0);
        s_run = add_rk(s_run, k_run, RC_T[fwd]);
        k_run = upd(k_run);
      end else begin
        k_run = inv_upd(k_run);
        s_run = add_rk(s_run, k_run, RC_T[RMAX - fwd]);
        s_run = sub_cells(perm(s_run, 1'b1), 1'b1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      sreg    <= '0;
      kreg    <= '0;
      k0_reg  <= '0;
      k40_reg <= '0;
      mode_r  <= 1'b0;
      kr      <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      sreg    <= '0;
      kreg    <= '0;
      k0_reg  <= '0;
      k40_reg <= '0;
      kr      <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.key_ld) begin
            kreg   <= bus.key_in;
            k0_reg <= bus.key_in;
            kr     <= 1'b0;
            cnt    <= '0;
          end else if (bus.start && kr) begin
            sreg   <= bus.data_in;
            mode_r <= bus.mode;
            kreg   <= bus.mode ? k40_reg : k0_reg;
            cnt    <= '0;
          end
        end
        KEY_PREP: begin
          kreg <= k_prep;
          cnt  <= last ? 6'd0 : cnt + 6'd1;
          if (last) begin
            k40_reg <= k_prep;
            kr      <= 1'b1;
          end
        end
        RUN: begin
          sreg <= s_run;
          kreg <= k_run;
          cnt  <= last ? 6'd0 : cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gift_128_core_param.sv
// tb_gift_128_core_param: scoreboard bench driving UNROLL=1/4/8 cores in lockstep.
// Key-clear scenario runs only when GIFT128_KEY_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_gift_128_core_param;
  localparam int NDUT = 3;
  localparam logic [127:0] K2  = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] KAT = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
  localparam logic [63:0]  SB  = 64'h1a4c6f392db7508e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] data_in = '0;
  logic         key_ld = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         key_clr = 1'b0;

  logic [NDUT-1:0] busy_w, done_w, kr_w;
  logic [127:0]    dout_w [NDUT];

  logic [127:0] exp_d [NDUT][$];
  int           exp_c [NDUT][$];
  int           n_done [NDUT];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ul(input int g);
    return (g == 0) ? 1 : (g == 1) ? 4 : 8;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int U = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    gift_128_core_param_if bus ();
    assign bus.key_in  = key_in;
    assign bus.key_ld  = key_ld;
    assign bus.mode    = mode;
    assign bus.data_in = data_in;
    assign bus.start   = start;
`ifdef GIFT128_KEY_CLEAR_EN
    assign bus.key_clr = key_clr;
`endif
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign kr_w[g]   = bus.key_ready;
    assign dout_w[g] = bus.data_out;

    gift_128_core_param #(.UNROLL(U), .ROUNDS(40)) u_dut (
      .clk_i   (clk),
      .reset_n (rst_n),
      .bus     (bus)
    );

    always @(negedge clk) begin
      if (bus.done) begin
        n_done[g]++;
        if (exp_d[g].size() == 0) begin
          chk($sformatf("u%0d_unexp_done", U), 128'(1), 128'(0));
        end else begin
          chk($sformatf("u%0d_data", U), bus.data_out,
              exp_d[g].pop_front());
          chk($sformatf("u%0d_lat", U), 128'(cyc),
              128'(exp_c[g].pop_front()));
        end
      end
    end
  end

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = SB << (4 * int'(x));
    return t[63:60];
  endfunction

  function automatic logic [127:0] upd_key(input logic [127:0] k);
    logic [15:0] k1, k0;
    k1 = k[31:16];
    k0 = k[15:0];
    return {(k1 >> 2) | (k1 << 14), (k0 >> 12) | (k0 << 4), k[127:32]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt,
                                           input logic [127:0] key);
    logic [127:0] s, k, t;
    logic [5:0]   c;
    s = pt;
    k = key;
    c = '0;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 32; i++) s[4*i +: 4] = sb(s[4*i +: 4]);
      t = '0;
      for (int i = 0; i < 128; i++)
        t[4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4)] = s[i];
      s = t;
      c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
      for (int i = 0; i < 32; i++) begin
        s[4*i+2] ^= k[64+i];
        s[4*i+1] ^= k[i];
      end
      s[127] ^= 1'b1;
      for (int j = 0; j < 6; j++) s[3+4*j] ^= c[j];
      k = upd_key(k);
    end
    return s;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((|busy_w) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 128'(1), 128'(0));
  endtask

  task automatic run_block(input logic m, input logic [127:0] din,
                           input logic [127:0] exp);
    wait_idle();
    mode = m;
    data_in = din;
    start = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      exp_d[g].push_back(exp);
      exp_c[g].push_back(cyc + 40 / ul(g) + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    int c0;
    wait_idle();
    key_in = k;
    key_ld = 1'b1;
    c0 = cyc;
    @(negedge clk);
    key_ld = 1'b0;
    while (cyc < c0 + 40) @(negedge clk);
    chk("kr_early", 128'(kr_w[0]), 128'(0));
    @(negedge clk);
    chk("kr_on", 128'(kr_w[0]), 128'(1));
    wait_idle();
    chk("kr_all", 128'(kr_w), 128'(3'b111));
  endtask

  task automatic flush();
    for (int g = 0; g < NDUT; g++) exp_d[g].delete();
    for (int g = 0; g < NDUT; g++) exp_c[g].delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d limit=60000", cyc);
    $fatal(1);
  end

  initial begin
    logic [127:0] pt, ct;
    int c0, nd;
    for (int g = 0; g < NDUT; g++) n_done[g] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy_w), 128'(0));
    chk("rst_done", 128'(done_w), 128'(0));
    chk("rst_kr", 128'(kr_w), 128'(0));
    chk("rst_dout", dout_w[0], 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    start = 1'b1;
    data_in = 128'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("nokey_busy", 128'(busy_w), 128'(0));
    chk("nokey_done", 128'(n_done[0]), 128'(0));

    load_key('0);
    run_block(1'b0, '0, KAT);
    run_block(1'b1, KAT, '0);

    load_key(K2);
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = ref_enc(pt, K2);
    run_block(1'b0, pt, ct);
    @(negedge clk);
    start = 1'b1;
    key_ld = 1'b1;
    data_in = ~pt;
    key_in = ~K2;
    @(negedge clk);
    start = 1'b0;
    key_ld = 1'b0;
    wait_idle();
    chk("busy_kr", 128'(kr_w), 128'(3'b111));
    run_block(1'b1, ct, pt);

    for (int i = 0; i < 200; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = ref_enc(pt, K2);
      run_block(1'b0, pt, ct);
      run_block(1'b1, ct, pt);
    end
    wait_idle();

    pt = 128'h0123456789abcdef0011223344556677;
    run_block(1'b0, pt, ref_enc(pt, K2));
    c0 = cyc;
    while (cyc < c0 + 20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy_w), 128'(0));
    chk("mid_rst_done", 128'(done_w), 128'(0));
    chk("mid_rst_kr", 128'(kr_w), 128'(0));
    chk("mid_rst_dout", dout_w[0], 128'(0));
    flush();
    nd = n_done[0];
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (45) @(negedge clk);
    chk("post_rst_busy", 128'(busy_w), 128'(0));
    chk("post_rst_done", 128'(n_done[0]), 128'(nd));

    load_key(K2);
    run_block(1'b0, pt, ref_enc(pt, K2));

`ifdef GIFT128_KEY_CLEAR_EN
    run_block(1'b0, ~pt, ref_enc(~pt, K2));
    @(negedge clk);
    key_clr = 1'b1;
    @(negedge clk);
    key_clr = 1'b0;
    chk("clr_busy", 128'(busy_w), 128'(0));
    chk("clr_dout", dout_w[0], 128'(0));
    chk("clr_kr", 128'(kr_w), 128'(0));
    flush();
    nd = n_done[0];
    repeat (45) @(negedge clk);
    chk("clr_nodone", 128'(n_done[0]), 128'(nd));
`endif

    wait_idle();
    @(negedge clk);
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("q_left%0d", g), 128'(exp_d[g].size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gift_128_core_param.md
Name: gift_128_core_param

Overview:
- Parametrised GIFT-128 block-cipher core. One datapath does both encryption and decryption, selected per block by `mode`.
- Rounds per clock are set by UNROLL.
- Replaces the 40-entry stored round-key table with an on-the-fly key schedule: the master key K0 and the final key K40 are precomputed once per key load.
- Sits behind the bus/AEAD wrapper as the single cipher engine.

Parameters:
- UNROLL, 1: rounds per clock. Legal values 1, 2, 4, 5, 8, 10, 20, 40 (divisors of 40); elaboration error otherwise.
- ROUNDS, 40: round count. Fixed at 40; elaboration error if changed.

Ports:
- clk_i  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- key_in  in  128  master key K0
- key_ld  in  1  pulse; load key_in and start key preparation
- key_ready  out  1  high when K0/K40 are valid
- mode  in  1  0 = encrypt, 1 = decrypt; sampled with start
- data_in  in  128  plaintext or ciphertext
- start  in  1  pulse; begin one block
- data_out  out  128  state register, continuously driven
- done  out  1  one-cycle pulse when data_out holds the result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk_i; reset_n is asynchronous, active-low. Reset clears all registers and outputs to 0: key_ready=0, done=0, busy=0, data_out=0, state=IDLE.
- FSM states: IDLE, KEY_PREP, RUN, DONE.
- IDLE:
  - key_ld has priority over start. key_ld: kreg<=key_in, k0_reg<=key_in, key_ready<=0, cnt<=0, go to KEY_PREP.
  - start with key_ready=1: state<=data_in, latch mode, go to RUN.
  - start with key_ready=0: ignored, no done.
- KEY_PREP: apply UpdateKey UNROLL times per cycle, for 40/UNROLL cycles. Then k40_reg<=kreg, key_ready<=1, return to IDLE.
- RUN: 40/UNROLL cycles, UNROLL rounds each.
  - Encryption round r = 0..39: SubCells -> PermBits -> AddRoundKey(Kr, RC[r]), then kreg<=UpdateKey(kreg). kreg starts at K0.
  - Decryption round r = 39..0: kreg starts at K40; key = InvUpdateKey(kreg) (= Kr); InvAddRoundKey(Kr, RC[r]) -> InvPermBits -> InvSubCells; kreg<=key.
- AddRoundKey:
  - U=k[95:64], V=k[31:0].
  - For i=0..31: s[4i+2]^=U[i], s[4i+1]^=V[i].
  - s[127]^=1; s[23,19,15,11,7,3]^=RC[5:0].
- RC table (r=0..39): 01 03 07 0F 1F 3E 3D 3B 37 2F 1E 3C 39 33 27 0E 1D 3A 35 2B 16 2C 18 30 21 02 05 0B 17 2E 1C 38 31 23 06 0D 1B 36 2D 1A.
- UpdateKey: k <= {k[17:16],k[31:18], k[11:0],k[15:12], k[127:32]}. InvUpdateKey is its exact inverse.
- DONE: done=1 for one cycle, data_out valid, return to IDLE. data_out holds its value until the next accepted start.
- Latency: start cycle, then 40/UNROLL RUN cycles, then 1 DONE cycle. Key preparation takes 40/UNROLL cycles.
- Boundary conditions:
  - start or key_ld while busy: ignored. No effect on the current operation, and key_ready is unchanged.
  - Back-to-back blocks: start is accepted in the IDLE cycle directly after DONE.
  - key_ready stays 1 across any number of blocks until the next key_ld.
  - Reset mid-operation: aborts immediately to reset values and key_ready=0; a key must be reloaded.

Optional Feature:
- Macro GIFT128_KEY_CLEAR_EN.
- Defined:
  - Adds input `key_clr` (1 bit).
  - When sampled high in any state, on the next edge: k0_reg, k40_reg, kreg and the state register all zeroed, key_ready=0, state=IDLE, no done pulse.
  - key_clr takes priority over key_ld and start.
- Undefined: port absent; key material is cleared only by reset_n.

Test Plan:
- UNROLL=1: key 0, key_ld -> key_ready after 40 cycles; encrypt data_in=0 -> done 41 cycles after start, data_out=cd0bd738388ad3f668b15a36ceb6ff92.
- Same key: decrypt cd0bd738388ad3f668b15a36ceb6ff92 -> data_out=0.
- UNROLL=1, 4 and 8: key fedcba9876543210fedcba9876543210, 200 random blocks -> enc then dec round-trips to the original. Encryption results match the reference model. RUN length 40/UNROLL cycles.
- start with key_ready=0 -> no busy, no done. start and key_ld pulsed during RUN -> ignored, result unchanged.
- Reset asserted at RUN cycle 20 -> all outputs 0 at once, key_ready=0. Subsequent start ignored until key_ld.
- GIFT128_KEY_CLEAR_EN defined: key_clr during RUN -> next cycle IDLE, data_out=0, key_ready=0, no done pulse.
